// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial word transmitter.
package serial_pkg;
  localparam int SER_WORD_W    = 8;
  localparam int SER_BIT_CNT_W = 3;

  typedef enum logic {IDLE, SEND} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, synchronous active-high reset, registered flags.
// Head word is read straight from the storage flops at rd_ptr.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;
  logic [CNT_W-1:0]  count_nxt;

  // Full/empty judged on pre-edge state: no write-through-pop when full.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/serial_word_tx.sv
// Bit-serial REQ/ACK/DATA responder: queues words, sends each LSB-first
// with ACK on bit 0. Optional counters under SERIAL_WORD_TX_STATS_EN.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int DATA_W = SER_WORD_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              FULL,
  output logic              EMPTY,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF,
  input  logic              OUT_REQ,
  output logic              OUT_ACK,
`ifdef SERIAL_WORD_TX_STATS_EN
  output logic              OUT_DATA,
  output logic [15:0]       SENT_CNT,
  output logic [7:0]        DROP_CNT
`else
  output logic              OUT_DATA
`endif
);
  localparam logic [SER_BIT_CNT_W-1:0] LAST_BIT = SER_BIT_CNT_W'(DATA_W - 1);

  tx_state_t                state, state_nxt;
  logic [SER_BIT_CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [DATA_W-1:0]        shreg, sh_nxt, head;
  logic                     ack_nxt, data_nxt, pop;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (WR_EN),
    .pop     (pop),
    .wr_data (WR_DATA),
    .rd_data (head),
    .full    (FULL),
    .empty   (EMPTY),
    .count   (COUNT)
  );

  // OUT_DATA is registered from the shift register's LSB, so the word
  // is shifted right as each bit is launched.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    sh_nxt    = shreg;
    ack_nxt   = 1'b0;
    data_nxt  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: if (OUT_REQ && !EMPTY) begin
        pop       = 1'b1;
        state_nxt = SEND;
        cnt_nxt   = '0;
        sh_nxt    = head >> 1;
        ack_nxt   = 1'b1;
        data_nxt  = head[0];
      end
      SEND: if (bit_cnt == LAST_BIT) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt  = bit_cnt + 1'b1;
        data_nxt = shreg[0];
        sh_nxt   = shreg >> 1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      OUT_ACK  <= 1'b0;
      OUT_DATA <= 1'b0;
      OVF      <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= cnt_nxt;
      shreg    <= sh_nxt;
      OUT_ACK  <= ack_nxt;
      OUT_DATA <= data_nxt;
      OVF      <= OVF | (WR_EN & FULL);
    end
  end

`ifdef SERIAL_WORD_TX_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      SENT_CNT <= '0;
      DROP_CNT <= '0;
    end else begin
      if (OUT_ACK) SENT_CNT <= SENT_CNT + 16'd1;
      if (WR_EN && FULL && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: words queued at write time are
// compared against bursts reassembled from OUT_ACK/OUT_DATA.
module tb_serial_word_tx;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              RST, WR_EN, OUT_REQ;
  logic [DATA_W-1:0] WR_DATA;
  logic              FULL, EMPTY, OVF, OUT_ACK, OUT_DATA;
  logic [CNT_W-1:0]  COUNT;
`ifdef SERIAL_WORD_TX_STATS_EN
  logic [15:0]       SENT_CNT;
  logic [7:0]        DROP_CNT;
`endif

  serial_word_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_EN    (WR_EN),
    .WR_DATA  (WR_DATA),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .COUNT    (COUNT),
    .OVF      (OVF),
    .OUT_REQ  (OUT_REQ),
    .OUT_ACK  (OUT_ACK),
`ifdef SERIAL_WORD_TX_STATS_EN
    .OUT_DATA (OUT_DATA),
    .SENT_CNT (SENT_CNT),
    .DROP_CNT (DROP_CNT)
`else
    .OUT_DATA (OUT_DATA)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [DATA_W-1:0] exp_q [$];
  int                ack_q [$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d, input bit accepted);
    WR_EN   = 1'b1;
    WR_DATA = d;
    if (accepted) exp_q.push_back(d);
    tick();
    WR_EN = 1'b0;
  endtask

  // Reassemble each burst; ACK must appear only on bit 0, DATA idles low.
  initial begin
    logic [DATA_W-1:0] bits;
    int k;
    bit on;
    on = 0; k = 0; bits = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        on = 0;
      end else if (!on) begin
        if (OUT_ACK) begin
          bits    = '0;
          bits[0] = OUT_DATA;
          k       = 1;
          on      = 1;
          ack_q.push_back(cyc);
        end else begin
          chk("idle_data", int'(OUT_DATA), 0);
        end
      end else begin
        chk("ack_mid", int'(OUT_ACK), 0);
        bits[k] = OUT_DATA;
        k++;
        if (k == DATA_W) begin
          on = 0;
          if (exp_q.size() == 0) chk("sb_extra", int'(bits), -1);
          else                   chk("word", int'(bits), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int n;
    RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; OUT_REQ = 1'b0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_ack", int'(OUT_ACK), 0);
    chk("rst_data", int'(OUT_DATA), 0);
    chk("rst_full", int'(FULL), 0);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_count", int'(COUNT), 0);
    chk("rst_ovf", int'(OVF), 0);

    // Single word, 1-cycle ACK latency.
    wr(8'hA5, 1);
    chk("t1_count1", int'(COUNT), 1);
    OUT_REQ = 1'b1;
    tick();
    chk("t1_ack", int'(OUT_ACK), 1);
    chk("t1_bit0", int'(OUT_DATA), 1);
    chk("t1_count0", int'(COUNT), 0);
    repeat (10) tick();
    chk("t1_data_after", int'(OUT_DATA), 0);
    chk("t1_sb", exp_q.size(), 0);
    OUT_REQ = 1'b0;

    // Three back-to-back bursts, ACKs 9 cycles apart.
    wr(8'h81, 1); wr(8'h7F, 1); wr(8'h00, 1);
    ack_q.delete();
    OUT_REQ = 1'b1;
    n = 0;
    while (ack_q.size() < 3 && n < 60) begin tick(); n++; end
    if (ack_q.size() < 3) chk("t2_timeout", ack_q.size(), 3);
    else begin
      chk("t2_gap1", ack_q[1] - ack_q[0], 9);
      chk("t2_gap2", ack_q[2] - ack_q[1], 9);
    end
    repeat (10) tick();
    chk("t2_empty", int'(EMPTY), 1);
    chk("t2_sb", exp_q.size(), 0);
    OUT_REQ = 1'b0;

    // Fill, then overflow: dropped word never sent.
    wr(8'h11, 1); wr(8'h22, 1); wr(8'h33, 1); wr(8'h44, 1);
    wr(8'h55, 0);
    chk("t3_full", int'(FULL), 1);
    chk("t3_count", int'(COUNT), DEPTH);
    chk("t3_ovf", int'(OVF), 1);
`ifdef SERIAL_WORD_TX_STATS_EN
    chk("t3_drop", int'(DROP_CNT), 1);
`endif
    OUT_REQ = 1'b1;
    repeat (45) tick();
    OUT_REQ = 1'b0;
    chk("t3_sb", exp_q.size(), 0);
    chk("t3_empty", int'(EMPTY), 1);
    chk("t3_ovf_sticky", int'(OVF), 1);

    // Reset at bit 3 of 0xF0 with another word still queued.
    wr(8'hF0, 1); wr(8'h0F, 1);
    OUT_REQ = 1'b1;
    tick();
    chk("t4_ack", int'(OUT_ACK), 1);
    repeat (3) tick();
    RST = 1'b1;
    exp_q.delete();
    tick();
    RST = 1'b0;
    chk("t4_ack0", int'(OUT_ACK), 0);
    chk("t4_data0", int'(OUT_DATA), 0);
    chk("t4_empty", int'(EMPTY), 1);
    chk("t4_count", int'(COUNT), 0);
    chk("t4_ovf", int'(OVF), 0);
    n = 0;
    repeat (12) begin tick(); n += int'(OUT_ACK); end
    chk("t4_no_ack", n, 0);
    OUT_REQ = 1'b0;

    // REQ pulse while empty is not latched.
    OUT_REQ = 1'b1; tick(); OUT_REQ = 1'b0;
    wr(8'h3C, 1);
    n = 0;
    repeat (5) begin tick(); n += int'(OUT_ACK); end
    chk("t5_no_ack", n, 0);
    OUT_REQ = 1'b1;
    tick();
    chk("t5_ack", int'(OUT_ACK), 1);
    OUT_REQ = 1'b0;
    repeat (10) tick();
    chk("t5_sb", exp_q.size(), 0);

    // Write into empty FIFO with REQ high: ACK two cycles after WR_EN.
    OUT_REQ = 1'b1;
    wr(8'h96, 1);
    chk("t6_no_bypass", int'(OUT_ACK), 0);
    tick();
    chk("t6_ack", int'(OUT_ACK), 1);
    OUT_REQ = 1'b0;
    repeat (10) tick();
    chk("t6_sb", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
